store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
// - FIFO between store-strobe generation and the data-memory write port; consumes the per-store byte strobe.
// - Queues single-cycle-core stores and drains them to memory under a valid/ready handshake.
// - Forwards buffered bytes to same-word loads, so loads always see program-order data.
// - bufferEmpty gates fence / halt.
// PARAMETERS
// - DEPTH       4   number of entries; power of 2, >= 2
// - ADDR_WIDTH  32  byte-address width
// PORTS
// - clk             in   1            rising-edge clock
// - resetN          in   1            asynchronous, active-low reset
// - storeValid      in   1            core presents a store this cycle
// - storeReady      out  1            buffer can accept (not full)
// - storeAddress    in   ADDR_WIDTH   byte address of store
// - storeData       in   32           raw rs2 value, unaligned (byte/half in low bits)
// - writeStrobe     in   4            byte-lane enables from strobe generation
// - memValid        out  1            head entry presented to memory
// - memReady        in   1            memory accepts head this cycle
// - memAddress      out  ADDR_WIDTH   word-aligned address, [1:0] = 2'b00
// - memWriteData    out  32           lane-aligned write data
// - memWriteStrobe  out  4            byte enables of head entry
// - loadAddress     in   ADDR_WIDTH   address of the current load (combinational lookup)
// - fwdMask         out  4            bytes of loadAddress word held in buffer
// - fwdData         out  32           lane-aligned forwarded bytes; lanes with fwdMask=0 are 0
// - bufferEmpty     out  1            no entries held
// BEHAVIOUR
// - Reset (resetN=0, async): pointers=0, count=0; every entry valid bit cleared.
//   - Outputs during reset: storeReady=1, memValid=0, memAddress=0, memWriteData=0, memWriteStrobe=0,
//     fwdMask=0, fwdData=0, bufferEmpty=1.
//   - Reset mid-drain discards all entries; no partial retirement is recorded.
// - Entry fields: wordAddr = storeAddress[ADDR_WIDTH-1:2]; data = storeData << (8*storeAddress[1:0]),
//   truncated to 32 bits; strobe = writeStrobe as given.
//   - The strobe is not re-validated against the address.
// - Push: storeValid && storeReady at a clock edge writes the entry at the tail and advances the tail.
// - storeReady = (count != DEPTH).
//   - Derived from registered count only; it does not depend on same-cycle pop.
//   - A full buffer refuses a push even when memReady=1 in that cycle.
// - writeStrobe == 4'b0000 with storeValid: handshake completes (storeReady as above) but nothing is
//   enqueued; count is unchanged.
// - Pop: memValid && memReady retires the head and advances the head pointer.
//   - memValid = (count != 0).
//   - memAddress/memWriteData/memWriteStrobe are driven from the head entry and held stable while
//     memValid && !memReady.
// - Simultaneous push and pop (count between 1 and DEPTH-1): count unchanged, both pointers advance.
// - count == 0 with push: the entry appears on the mem* ports the following cycle (latency 1); no bypass.
// - Pointers are log2(DEPTH)+1 bits with a wrap bit.
//   - full: indices equal, wrap bits differ.
//   - empty: pointers equal.
// - Forwarding is combinational: compare loadAddress[ADDR_WIDTH-1:2] against every valid entry.
//   - Each byte lane takes the youngest matching entry whose strobe bit is set.
//   - fwdMask = OR of matching strobes.
//   - The head entry popped this cycle still forwards, since state updates at the edge.
//   - Merging partial hits with memory data is the consumer's job.
// - bufferEmpty = (count == 0).
// - No FSM beyond the FIFO; the state is headPtr, tailPtr and entry valid bits.
// STRUCTURE
// - Shared package (coreTypes, existing): typedef storeEntry_t {wordAddr, data[31:0], strobe[3:0]}.
//   - Also holds the STRB_WORD/STRB_NONE constants.
// - Sub-module fwd_lane_select: per-byte priority select (youngest-first) over DEPTH entries.
//   - Instantiated once per lane (4x).
// - The FIFO storage and pointers stay in this module.
// TESTING
// - Reset, then sw 0x100 data 0xDEADBEEF strobe 1111 with memReady=0:
//   memValid=1 next cycle, memAddress=0x100, memWriteData=0xDEADBEEF, memWriteStrobe=1111; held 3 cycles.
//   - memReady=1 then retires it and bufferEmpty=1.
// - sb at 0x203 data 0x000000AB strobe 1000: memAddress=0x200, memWriteData=0xAB000000, memWriteStrobe=1000.
// - Fill 4 stores with memReady=0: storeReady=0 after the 4th.
//   - A 5th storeValid is not accepted.
//   - memReady=1 with storeValid=1: pop takes place and storeReady returns to 1 the next cycle.
//   - Drain order matches push order.
// - Forwarding:
//   - sb 0x300=0x11 strobe 0001, then sb 0x300=0x22 strobe 0001, then sh 0x302 data 0x3344 strobe 1100.
//   - Load 0x300 -> fwdMask=1101, fwdData=0x33440022.
//   - Load 0x304 -> fwdMask=0000, fwdData=0.
// - Zero strobe: storeValid with writeStrobe=0000 -> accepted, bufferEmpty stays 1, memValid stays 0.
// - Reset mid-operation: 3 entries queued, resetN low for 1 cycle asynchronously mid-cycle.
//   - Immediately memValid=0, bufferEmpty=1, fwdMask=0.
//   - After release, the next push is drained at memAddress from that push only.

Source files
------------

// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer_pkg
//  Brief    : Shared types and constants for the store buffer slice.
//  Revision : 1.0 - initial release
// ============================================================================
package store_buffer_pkg;

  // Entry word address is sized for the widest supported byte address.
  // Narrower configurations zero-extend into it.
  localparam int SB_MAX_ADDR_WIDTH = 64;
  localparam int SB_WORD_ADDR_W    = SB_MAX_ADDR_WIDTH - 2;

  localparam logic [3:0] STRB_WORD = 4'b1111;
  localparam logic [3:0] STRB_NONE = 4'b0000;

  typedef struct packed {
    logic [SB_WORD_ADDR_W-1:0] wordAddr;
    logic [31:0]               data;
    logic [3:0]                strobe;
  } storeEntry_t;

  // Move a low-justified byte/half/word into its byte lanes.
  function automatic logic [31:0] align_store_data(input logic [31:0] data,
                                                   input logic [1:0]  byteOff);
    return data << {byteOff, 3'b000};
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_fwd_lane_select.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_lane_select
//  Brief    : Per-byte-lane priority select over the buffer entries; the
//             youngest hitting entry wins. No hit yields zero data.
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_lane_select #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic [IDX_W-1:0]      headIdx_i,
  input  logic [DEPTH-1:0]      hit_i,
  input  logic [DEPTH-1:0][7:0] laneData_i,
  output logic                  hit_o,
  output logic [7:0]            data_o
);

  logic [IDX_W-1:0] idx;

  // Walk entries oldest to youngest starting at the head; the last hit seen
  // is the youngest, so it overrides any older one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = 8'h00;
    idx    = headIdx_i;
    for (int k = 0; k < DEPTH; k++) begin
      idx = headIdx_i + IDX_W'(k);
      if (hit_i[idx]) begin
        hit_o  = 1'b1;
        data_o = laneData_i[idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer
//  Brief    : Store FIFO between strobe generation and the data-memory write
//             port, with same-word byte forwarding to loads.
//  Revision : 1.0 - initial release
// ============================================================================
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  storeValid,
  output logic                  storeReady,
  input  logic [ADDR_WIDTH-1:0] storeAddress,
  input  logic [31:0]           storeData,
  input  logic [3:0]            writeStrobe,
  output logic                  memValid,
  input  logic                  memReady,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic [31:0]           memWriteData,
  output logic [3:0]            memWriteStrobe,
  input  logic [ADDR_WIDTH-1:0] loadAddress,
  output logic [3:0]            fwdMask,
  output logic [31:0]           fwdData,
  output logic                  bufferEmpty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  storeEntry_t      entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] headPtr_q, headPtr_d;
  logic [PTR_W-1:0] tailPtr_q, tailPtr_d;

  logic [IDX_W-1:0] headIdx, tailIdx;
  logic             empty, full, push, pop;
  storeEntry_t      headEntry, newEntry;

  logic [SB_WORD_ADDR_W-1:0] loadWord;
  logic [DEPTH-1:0]          match;

  // Byte offset of a load is irrelevant: forwarding is per word, per lane.
  logic w_unused_load_lsb;
  assign w_unused_load_lsb = ^loadAddress[1:0];

  assign headIdx = headPtr_q[IDX_W-1:0];
  assign tailIdx = tailPtr_q[IDX_W-1:0];
  assign empty   = (headPtr_q == tailPtr_q);
  assign full    = (headIdx == tailIdx) && (headPtr_q[IDX_W] != tailPtr_q[IDX_W]);

  assign storeReady  = !full;
  assign memValid    = !empty;
  assign bufferEmpty = empty;

  // A zero-strobe store handshakes normally but never occupies an entry.
  assign push = storeValid && !full && (writeStrobe != STRB_NONE);
  assign pop  = !empty && memReady;

  assign newEntry.wordAddr = SB_WORD_ADDR_W'(storeAddress[ADDR_WIDTH-1:2]);
  assign newEntry.data     = align_store_data(storeData, storeAddress[1:0]);
  assign newEntry.strobe   = writeStrobe;

  // Head fields are masked while empty so stale storage never leaks out.
  assign headEntry      = entry_q[headIdx];
  assign memAddress     = empty ? '0 : {headEntry.wordAddr[ADDR_WIDTH-3:0], 2'b00};
  assign memWriteData   = empty ? '0 : headEntry.data;
  assign memWriteStrobe = empty ? '0 : headEntry.strobe;

  // Pointer and valid-bit next state; push and pop may both fire.
  always_comb begin
    headPtr_d = headPtr_q;
    tailPtr_d = tailPtr_q;
    valid_d   = valid_q;
    if (pop) begin
      valid_d[headIdx] = 1'b0;
      headPtr_d        = headPtr_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[tailIdx] = 1'b1;
      tailPtr_d        = tailPtr_q + PTR_W'(1);
    end
  end

  // FIFO control state; reset discards every queued entry.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      headPtr_q <= '0;
      tailPtr_q <= '0;
      valid_q   <= '0;
    end else begin
      headPtr_q <= headPtr_d;
      tailPtr_q <= tailPtr_d;
      valid_q   <= valid_d;
    end
  end

  // Entry storage, written at the tail on an accepted push.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else if (push) begin
      entry_q[tailIdx] <= newEntry;
    end
  end

  // ---------------------------------------------------------------- forwarding
  assign loadWord = SB_WORD_ADDR_W'(loadAddress[ADDR_WIDTH-1:2]);

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign match[i] = valid_q[i] && (entry_q[i].wordAddr == loadWord);
  end

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [DEPTH-1:0]      laneHit;
    logic [DEPTH-1:0][7:0] laneData;

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      assign laneHit[e]  = match[e] && entry_q[e].strobe[l];
      assign laneData[e] = entry_q[e].data[8*l +: 8];
    end

    fwd_lane_select #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
    ) u_sel (
      .headIdx_i  (headIdx),
      .hit_i      (laneHit),
      .laneData_i (laneData),
      .hit_o      (fwdMask[l]),
      .data_o     (fwdData[8*l +: 8])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_buffer
//  Brief    : Directed self-checking bench for store_buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk;
  logic        resetN;
  logic        storeValid;
  logic        storeReady;
  logic [31:0] storeAddress;
  logic [31:0] storeData;
  logic [3:0]  writeStrobe;
  logic        memValid;
  logic        memReady;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [3:0]  memWriteStrobe;
  logic [31:0] loadAddress;
  logic [3:0]  fwdMask;
  logic [31:0] fwdData;
  logic        bufferEmpty;

  int n_vec = 0;
  int n_err = 0;

  store_buffer #(
    .DEPTH      (4),
    .ADDR_WIDTH (32)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .storeValid     (storeValid),
    .storeReady     (storeReady),
    .storeAddress   (storeAddress),
    .storeData      (storeData),
    .writeStrobe    (writeStrobe),
    .memValid       (memValid),
    .memReady       (memReady),
    .memAddress     (memAddress),
    .memWriteData   (memWriteData),
    .memWriteStrobe (memWriteStrobe),
    .loadAddress    (loadAddress),
    .fwdMask        (fwdMask),
    .fwdData        (fwdData),
    .bufferEmpty    (bufferEmpty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    storeValid   = 1'b1;
    storeAddress = a;
    storeData    = d;
    writeStrobe  = s;
    tick();
    storeValid   = 1'b0;
  endtask

  initial begin
    resetN       = 1'b0;
    storeValid   = 1'b0;
    storeAddress = '0;
    storeData    = '0;
    writeStrobe  = '0;
    memReady     = 1'b0;
    loadAddress  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_ready", storeReady, 1);
    chk("rst_memValid", memValid, 0);
    chk("rst_memAddr", memAddress, 0);
    chk("rst_memData", memWriteData, 0);
    chk("rst_memStrb", memWriteStrobe, 0);
    chk("rst_fwdMask", fwdMask, 0);
    chk("rst_fwdData", fwdData, 0);
    chk("rst_empty", bufferEmpty, 1);
    resetN = 1'b1;
    tick();

    // Full-word store, held while memory stalls
    push(32'h100, 32'hDEADBEEF, STRB_WORD);
    chk("sw_valid", memValid, 1);
    chk("sw_addr", memAddress, 32'h100);
    chk("sw_data", memWriteData, 32'hDEADBEEF);
    chk("sw_strb", memWriteStrobe, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sw_hold_valid", memValid, 1);
      chk("sw_hold_addr", memAddress, 32'h100);
      chk("sw_hold_data", memWriteData, 32'hDEADBEEF);
    end
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    chk("sw_retire_empty", bufferEmpty, 1);
    chk("sw_retire_valid", memValid, 0);

    // Byte store to the top lane
    push(32'h203, 32'h000000AB, 4'b1000);
    chk("sb_addr", memAddress, 32'h200);
    chk("sb_data", memWriteData, 32'hAB000000);
    chk("sb_strb", memWriteStrobe, 4'b1000);
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    chk("sb_retire_empty", bufferEmpty, 1);

    // Fill to capacity, refuse a 5th, then drain in order
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", storeReady, 1);
      push(32'h400 + 4 * i, 32'h1000 + i, STRB_WORD);
    end
    chk("full_ready", storeReady, 0);
    storeValid   = 1'b1;
    storeAddress = 32'h500;
    storeData    = 32'h5555;
    writeStrobe  = STRB_WORD;
    tick();
    chk("full_refuse_ready", storeReady, 0);
    chk("full_head_addr", memAddress, 32'h400);
    chk("full_head_data", memWriteData, 32'h1000);
    memReady = 1'b1;
    tick();
    storeValid = 1'b0;
    memReady   = 1'b0;
    chk("full_pop_ready", storeReady, 1);
    for (int i = 1; i < 4; i++) begin
      chk("drain_addr", memAddress, 32'h400 + 4 * i);
      chk("drain_data", memWriteData, 32'h1000 + i);
      memReady = 1'b1;
      tick();
      memReady = 1'b0;
    end
    chk("drain_empty", bufferEmpty, 1);

    // Forwarding: youngest byte wins per lane
    push(32'h300, 32'h11, 4'b0001);
    push(32'h300, 32'h22, 4'b0001);
    push(32'h302, 32'h3344, 4'b1100);
    loadAddress = 32'h300;
    #1;
    chk("fwd300_mask", fwdMask, 4'b1101);
    chk("fwd300_data", fwdData, 32'h33440022);
    loadAddress = 32'h304;
    #1;
    chk("fwd304_mask", fwdMask, 0);
    chk("fwd304_data", fwdData, 0);
    loadAddress = 32'h302;
    #1;
    chk("fwd302_mask", fwdMask, 4'b1101);
    chk("fwd302_data", fwdData, 32'h33440022);
    loadAddress = 32'h300;
    memReady = 1'b1;
    #1;
    chk("fwd_popcycle_mask", fwdMask, 4'b1101);
    tick();
    memReady = 1'b0;
    chk("fwd_afterpop_mask", fwdMask, 4'b1101);
    chk("fwd_afterpop_data", fwdData, 32'h33440022);
    chk("fwd_afterpop_head", memWriteData, 32'h22);
    memReady = 1'b1;
    repeat (2) tick();
    memReady = 1'b0;
    chk("fwd_drained_mask", fwdMask, 0);
    chk("fwd_drained_data", fwdData, 0);
    chk("fwd_drained_empty", bufferEmpty, 1);

    // Zero strobe: accepted, not enqueued
    storeValid   = 1'b1;
    storeAddress = 32'h800;
    storeData    = 32'h99;
    writeStrobe  = STRB_NONE;
    #1;
    chk("zs_ready", storeReady, 1);
    tick();
    storeValid = 1'b0;
    chk("zs_empty", bufferEmpty, 1);
    chk("zs_valid", memValid, 0);

    // Asynchronous reset mid-operation
    push(32'h600, 32'h60, STRB_WORD);
    push(32'h604, 32'h61, STRB_WORD);
    push(32'h608, 32'h62, STRB_WORD);
    loadAddress = 32'h600;
    #1;
    chk("pre_rst_valid", memValid, 1);
    chk("pre_rst_fwd", fwdMask, 4'b1111);
    #1;
    resetN = 1'b0;
    #1;
    chk("async_rst_valid", memValid, 0);
    chk("async_rst_empty", bufferEmpty, 1);
    chk("async_rst_fwd", fwdMask, 0);
    chk("async_rst_ready", storeReady, 1);
    #10;
    resetN = 1'b1;
    tick();
    chk("post_rst_empty", bufferEmpty, 1);
    push(32'h700, 32'h77, STRB_WORD);
    chk("post_rst_addr", memAddress, 32'h700);
    chk("post_rst_data", memWriteData, 32'h77);
    chk("post_rst_valid", memValid, 1);
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    chk("post_rst_drained", bufferEmpty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
